countdown_timer: RTL and testbench



---
 rtl/countdown_timer_pkg.sv | 12 +
 rtl/countdown_timer_decrementer.sv | 39 +++
 rtl/countdown_timer.sv | 132 +++++++++++++
 tb/tb_countdown_timer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_timer_pkg.sv
// rtl/countdown_timer_pkg.sv - shared types and defaults for the countdown timer
package countdown_timer_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/countdown_timer_decrementer.sv
// rtl/countdown_timer_decrementer.sv - gate-level ripple-borrow subtract-by-one
module countdown_timer_decrementer #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  // Subtrahend is the constant 1: only bit 0 subtracts, upper stages just ripple the borrow.
  localparam logic [WIDTH-1:0] SUBTRAHEND = WIDTH'(1);

  wire [WIDTH:0] borrow;

  assign borrow[0] = 1'b0;

  // One full subtractor per bit, borrow rippling from bit 0 upward.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fs
    wire b_bit;
    wire diff_ab;
    wire not_a;
    wire not_diff_ab;
    wire borrow_gen;
    wire borrow_prop;

    assign b_bit = SUBTRAHEND[i];

    xor u_x1 (diff_ab, a[i], b_bit);
    xor u_x2 (d[i], diff_ab, borrow[i]);
    not u_n1 (not_a, a[i]);
    and u_a1 (borrow_gen, not_a, b_bit);
    not u_n2 (not_diff_ab, diff_ab);
    and u_a2 (borrow_prop, not_diff_ab, borrow[i]);
    or  u_o1 (borrow[i+1], borrow_gen, borrow_prop);
  end

  assign bout = borrow[WIDTH];

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counter timer with done pulse; option COUNTDOWN_TIMER_AUTO_RELOAD_EN
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] count_q;
  logic             done_q;
  logic [WIDTH-1:0] dec_d;
  logic             dec_bout;
  logic             at_one;
  logic             step_run;
  logic             reload_tick;

  countdown_timer_decrementer #(
    .WIDTH(WIDTH)
  ) u_dec (
    .a    (count_q),
    .d    (dec_d),
    .bout (dec_bout)
  );

  // count==1 exactly when the decrement lands on zero without borrowing out of the top.
  assign at_one   = (dec_d == ZERO) && !dec_bout;
  assign step_run = (state_q == RUN) && !stop && en;

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q;

  assign reload_tick = step_run && at_one;

  // Reload value captured on every nonzero start, reused at each terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reload_q <= ZERO;
    end else if (state_q == IDLE && start && load_val != ZERO) begin
      reload_q <= load_val;
    end
  end
`else
  assign reload_tick = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; stop outranks en, and the unused code falls back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (load_val == ZERO) ? DONE : RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (en && at_one && !reload_tick) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    busy = (state_q == RUN);
  end

  // Counter register: load on start, decrement on enabled RUN cycles, reload or clear at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= ZERO;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            count_q <= load_val;
          end
        end
        RUN: begin
          if (step_run) begin
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
            count_q <= at_one ? reload_q : dec_d;
`else
            count_q <= dec_d;
`endif
          end
        end
        DONE:    count_q <= ZERO;
        default: count_q <= count_q;
      endcase
    end
  end

  // Done pulse registered alongside entry into DONE, or alongside a reload tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state_d == DONE) || reload_tick;
    end
  end

  assign count = count_q;
  assign done  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - directed self-checking bench for countdown_timer
module tb_countdown_timer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] load_val;
  logic       en;
  logic       stop;
  logic [3:0] count;
  logic       busy;
  logic       done;

  logic [3:0] dec_a;
  logic [3:0] dec_d;
  logic       dec_bout;

  int n_checks;
  int n_pass;

  countdown_timer #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .load_val (load_val),
    .en       (en),
    .stop     (stop),
    .count    (count),
    .busy     (busy),
    .done     (done)
  );

  countdown_timer_decrementer #(.WIDTH(4)) u_dec (
    .a    (dec_a),
    .d    (dec_d),
    .bout (dec_bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; load_val = 4'd0; en = 1'b0; stop = 1'b0; dec_a = 4'd0;
    #12;
    n_checks++;
    if ({count, busy, done} !== {4'd0, 1'b0, 1'b0})
      $display("FAIL reset_state: got count=%0d busy=%0b done=%0b, want 0 0 0", count, busy, done);
    else n_pass++;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_decrementer();
    logic [3:0] exp_d;
    logic       exp_b;
    for (int i = 0; i < 16; i++) begin
      dec_a = 4'(i);
      exp_d = 4'((i + 15) % 16);
      exp_b = (i == 0);
      #1;
      n_checks++;
      if ({dec_d, dec_bout} !== {exp_d, exp_b})
        $display("FAIL dec_%0d: got d=%0d bout=%0b, want d=%0d bout=%0b", i, dec_d, dec_bout, exp_d, exp_b);
      else n_pass++;
    end
  endtask

  task automatic test_one_shot();
    start = 1'b1; load_val = 4'd5; en = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if ({count, busy, done} !== {4'd5, 1'b1, 1'b0})
      $display("FAIL one_shot_load: got count=%0d busy=%0b done=%0b, want 5 1 0", count, busy, done);
    else n_pass++;
    for (int i = 4; i >= 0; i--) begin
      step();
      n_checks++;
      if ({count, busy, done} !== {4'(i), (i != 0), (i == 0)})
        $display("FAIL one_shot_cnt%0d: got count=%0d busy=%0b done=%0b, want %0d %0b %0b",
                 i, count, busy, done, i, (i != 0), (i == 0));
      else n_pass++;
    end
    step();
    n_checks++;
    if ({count, busy, done} !== {4'd0, 1'b0, 1'b0})
      $display("FAIL one_shot_after: got count=%0d busy=%0b done=%0b, want 0 0 0", count, busy, done);
    else n_pass++;
    en = 1'b0;
  endtask

  task automatic test_enable_stop();
    logic [3:0] exp_cnt [4] = '{4'd5, 4'd5, 4'd4, 4'd4};
    start = 1'b1; load_val = 4'd6; en = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en = (i % 2 == 0);
      step();
      n_checks++;
      if ({count, busy} !== {exp_cnt[i], 1'b1})
        $display("FAIL en_gate_%0d: got count=%0d busy=%0b, want %0d 1", i, count, busy, exp_cnt[i]);
      else n_pass++;
    end
    stop = 1'b1; en = 1'b1;
    step();
    stop = 1'b0; en = 1'b0;
    n_checks++;
    if ({count, busy, done} !== {4'd4, 1'b0, 1'b0})
      $display("FAIL stop_prio: got count=%0d busy=%0b done=%0b, want 4 0 0", count, busy, done);
    else n_pass++;
    step();
    n_checks++;
    if ({count, busy, done} !== {4'd4, 1'b0, 1'b0})
      $display("FAIL stop_hold: got count=%0d busy=%0b done=%0b, want 4 0 0", count, busy, done);
    else n_pass++;
  endtask

  task automatic test_zero_load();
    start = 1'b1; load_val = 4'd0;
    step();
    start = 1'b0;
    n_checks++;
    if ({count, busy, done} !== {4'd0, 1'b0, 1'b1})
      $display("FAIL zero_load_done: got count=%0d busy=%0b done=%0b, want 0 0 1", count, busy, done);
    else n_pass++;
    step();
    n_checks++;
    if ({count, busy, done} !== {4'd0, 1'b0, 1'b0})
      $display("FAIL zero_load_end: got count=%0d busy=%0b done=%0b, want 0 0 0", count, busy, done);
    else n_pass++;
  endtask

  task automatic test_max_load();
    int cycles;
    start = 1'b1; load_val = 4'd15; en = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if ({count, busy} !== {4'd15, 1'b1})
      $display("FAIL max_load: got count=%0d busy=%0b, want 15 1", count, busy);
    else n_pass++;
    cycles = 0;
    for (int k = 1; k <= 40 && cycles == 0; k++) begin
      if (k == 3) begin
        start = 1'b1; load_val = 4'd3;
      end else begin
        start = 1'b0;
      end
      step();
      if (k == 3) begin
        n_checks++;
        if ({count, busy} !== {4'd12, 1'b1})
          $display("FAIL start_in_run: got count=%0d busy=%0b, want 12 1", count, busy);
        else n_pass++;
      end
      if (done === 1'b1) cycles = k;
    end
    n_checks++;
    if (cycles !== 15)
      $display("FAIL max_cycles: got %0d enabled cycles to done, want 15 (0 = timeout)", cycles);
    else n_pass++;
    en = 1'b0;
    step();
  endtask

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    logic [3:0] exp_c;
    start = 1'b1; load_val = 4'd3; en = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_c = 4'(3 - (k % 3));
      n_checks++;
      if ({count, busy, done} !== {exp_c, 1'b1, (k % 3 == 0)})
        $display("FAIL auto_reload_%0d: got count=%0d busy=%0b done=%0b, want %0d 1 %0b",
                 k, count, busy, done, exp_c, (k % 3 == 0));
      else n_pass++;
    end
    stop = 1'b1;
    step();
    stop = 1'b0; en = 1'b0;
    n_checks++;
    if ({busy, done} !== {1'b0, 1'b0})
      $display("FAIL auto_reload_stop: got busy=%0b done=%0b, want 0 0", busy, done);
    else n_pass++;
  endtask
`endif

  task automatic test_reset_mid_run();
    start = 1'b1; load_val = 4'd9; en = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    n_checks++;
    if ({count, busy} !== {4'd6, 1'b1})
      $display("FAIL mid_run_pre: got count=%0d busy=%0b, want 6 1", count, busy);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({count, busy, done} !== {4'd0, 1'b0, 1'b0})
      $display("FAIL mid_run_reset: got count=%0d busy=%0b done=%0b, want 0 0 0", count, busy, done);
    else n_pass++;
    en = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({count, busy, done} !== {4'd0, 1'b0, 1'b0})
      $display("FAIL mid_run_idle: got count=%0d busy=%0b done=%0b, want 0 0 0", count, busy, done);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_decrementer();
    test_one_shot();
    test_enable_stop();
    test_zero_load();
    test_max_load();
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    test_auto_reload();
`endif
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
